// File: rtl/sm3_pkg.sv
// rtl/sm3_pkg.sv - shared widths, SM3 IV and controller state encoding
package sm3_pkg;

    localparam int BLOCK_W  = 512;
    localparam int WORD_W   = 32;
    localparam int LEN_W    = 64;
    localparam int DIGEST_W = 256;

    localparam logic [DIGEST_W-1:0] SM3_IV =
        256'h7380166f4914b2b9172442d7da8a0600a96f30bc163138aae38dee4db0fb0e4e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FILL,
        ST_PADZ,
        ST_LEN,
        ST_RUN,
        ST_DONE
    } sm3_state_e;

endpackage

// File: rtl/sm3_last_word_pad.sv
// rtl/sm3_last_word_pad.sv - byte mask and 0x80 marker insertion for one message word
module sm3_last_word_pad
    import sm3_pkg::*;
(
    input  logic [WORD_W-1:0] data,
    input  logic [2:0]        nbytes,
    input  logic              last,
    output logic [WORD_W-1:0] word,
    output logic              marker_pending
);

    logic [2:0] nb;

    assign nb             = (nbytes > 3'd4) ? 3'd4 : nbytes;
    assign marker_pending = last && (nb == 3'd4);

    // Byte 0 sits in the top lane; the marker follows the last valid byte.
    always_comb begin
        word = '0;
        for (int i = 0; i < 4; i++) begin
            if (i < int'(nb)) begin
                word[31-8*i -: 8] = data[31-8*i -: 8];
            end else if (last && (i == int'(nb))) begin
                word[31-8*i -: 8] = 8'h80;
            end
        end
    end

endmodule

// File: rtl/sm3_pad_ctrl.sv
// rtl/sm3_pad_ctrl.sv - SM3 block assembly, padding and compression sequencing (option: SM3_BYTE_SWAP_EN)
module sm3_pad_ctrl
    import sm3_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [WORD_W-1:0]   in_data,
    input  logic [2:0]          in_bytes,
    input  logic                in_last,
    output logic                cf_start,
    output logic [DIGEST_W-1:0] cf_v1,
    output logic [BLOCK_W-1:0]  cf_block,
    input  logic                cf_end,
    input  logic [DIGEST_W-1:0] cf_v2,
    output logic [DIGEST_W-1:0] digest,
    output logic                digest_valid
);

    sm3_state_e          state;
    logic [3:0]          widx;
    logic [LEN_W-1:0]    len;
    logic                pad_done;
    logic                msg_end;
    logic                is_final;
    logic [DIGEST_W-1:0] v_r;
    logic [WORD_W-1:0]   blk [16];

    logic [WORD_W-1:0]   src_word;
    logic [WORD_W-1:0]   pad_word;
    logic                pad_pending;
    logic                accept;
    logic [3:0]          widx_eff;
    logic [LEN_W-1:0]    len_eff;
    logic [2:0]          nb;

`ifdef SM3_BYTE_SWAP_EN
    assign src_word = {in_data[7:0], in_data[15:8], in_data[23:16], in_data[31:24]};
`else
    assign src_word = in_data;
`endif

    sm3_last_word_pad u_last_word_pad (
        .data           (src_word),
        .nbytes         (in_bytes),
        .last           (in_last),
        .word           (pad_word),
        .marker_pending (pad_pending)
    );

    // The first word of a message is taken in IDLE, so it must see a cleared index and length.
    assign accept   = in_valid & in_ready;
    assign widx_eff = (state == ST_IDLE) ? 4'd0 : widx;
    assign len_eff  = (state == ST_IDLE) ? '0 : len;
    assign nb       = (in_bytes > 3'd4) ? 3'd4 : in_bytes;
    assign cf_v1    = v_r;

    always_comb begin
        cf_block = '0;
        for (int i = 0; i < 16; i++) begin
            cf_block[BLOCK_W-1-WORD_W*i -: WORD_W] = blk[i];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= ST_IDLE;
            widx         <= '0;
            len          <= '0;
            pad_done     <= 1'b0;
            msg_end      <= 1'b0;
            is_final     <= 1'b0;
            v_r          <= SM3_IV;
            for (int i = 0; i < 16; i++) blk[i] <= '0;
            digest       <= '0;
            digest_valid <= 1'b0;
            cf_start     <= 1'b0;
            in_ready     <= 1'b0;
        end else begin
            digest_valid <= 1'b0;
            case (state)
                ST_IDLE, ST_FILL: begin
                    if (state == ST_IDLE) begin
                        v_r      <= SM3_IV;
                        len      <= '0;
                        widx     <= '0;
                        pad_done <= 1'b0;
                        msg_end  <= 1'b0;
                        in_ready <= 1'b1;
                    end
                    if (accept) begin
                        blk[widx_eff] <= pad_word;
                        len           <= len_eff + {58'd0, nb, 3'd0};
                        if (!in_last) begin
                            if (widx_eff == 4'd15) begin
                                state    <= ST_RUN;
                                is_final <= 1'b0;
                                cf_start <= 1'b1;
                                in_ready <= 1'b0;
                            end else begin
                                widx  <= widx_eff + 4'd1;
                                state <= ST_FILL;
                            end
                        end else begin
                            msg_end  <= 1'b1;
                            pad_done <= !pad_pending;
                            in_ready <= 1'b0;
                            if (widx_eff == 4'd15) begin
                                state    <= ST_RUN;
                                is_final <= 1'b0;
                                cf_start <= 1'b1;
                            end else begin
                                widx  <= widx_eff + 4'd1;
                                state <= (widx_eff == 4'd13 && !pad_pending) ? ST_LEN : ST_PADZ;
                            end
                        end
                    end
                end
                ST_PADZ: begin
                    blk[widx] <= pad_done ? 32'h0000_0000 : 32'h8000_0000;
                    pad_done  <= 1'b1;
                    // Padding that reaches words 14/15 spills the length into a fresh block.
                    if (widx == 4'd15) begin
                        state    <= ST_RUN;
                        is_final <= 1'b0;
                        cf_start <= 1'b1;
                    end else begin
                        widx <= widx + 4'd1;
                        if (widx == 4'd13) state <= ST_LEN;
                    end
                end
                ST_LEN: begin
                    blk[widx] <= widx[0] ? len[31:0] : len[63:32];
                    if (widx == 4'd15) begin
                        state    <= ST_RUN;
                        is_final <= 1'b1;
                        cf_start <= 1'b1;
                    end else begin
                        widx <= widx + 4'd1;
                    end
                end
                ST_RUN: begin
                    if (cf_end) begin
                        v_r      <= cf_v2;
                        cf_start <= 1'b0;
                        widx     <= '0;
                        if (is_final) begin
                            state <= ST_DONE;
                        end else if (msg_end) begin
                            state <= ST_PADZ;
                        end else begin
                            state    <= ST_FILL;
                            in_ready <= 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    digest       <= v_r;
                    digest_valid <= 1'b1;
                    state        <= ST_IDLE;
                    in_ready     <= 1'b1;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sm3_pad_ctrl.sv
// tb/tb_sm3_pad_ctrl.sv - randomized self-checking bench with SM3 core and padding reference model
module tb_sm3_pad_ctrl;

    typedef logic [7:0] bq_t [$];

    localparam logic [255:0] IV =
        256'h7380166f4914b2b9172442d7da8a0600a96f30bc163138aae38dee4db0fb0e4e;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [31:0]  in_data;
    logic [2:0]   in_bytes;
    logic         in_last;
    logic         cf_start;
    logic [255:0] cf_v1;
    logic [511:0] cf_block;
    logic         cf_end;
    logic [255:0] cf_v2;
    logic [255:0] digest;
    logic         digest_valid;

    int checks = 0;
    int errors = 0;
    int n_starts = 0;
    int dig_count = 0;
    int since_end = 100;
    int lat_force = 0;

    logic [511:0] exp_blk [$];
    logic [255:0] exp_v1 [$];
    logic [255:0] exp_dig [$];
    logic [511:0] first_blk, last_blk, held_blk;
    logic [255:0] held_v1, held_dig, last_dut_dig;

    sm3_pad_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .in_bytes     (in_bytes),
        .in_last      (in_last),
        .cf_start     (cf_start),
        .cf_v1        (cf_v1),
        .cf_block     (cf_block),
        .cf_end       (cf_end),
        .cf_v2        (cf_v2),
        .digest       (digest),
        .digest_valid (digest_valid)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s", name);
    endtask

    // SM3 compression function, written straight from the algorithm definition.
    function automatic logic [31:0] rotl(input logic [31:0] x, input int n);
        int s;
        s = n % 32;
        if (s == 0) return x;
        return (x << s) | (x >> (32 - s));
    endfunction

    function automatic logic [31:0] p0(input logic [31:0] x);
        return x ^ rotl(x, 9) ^ rotl(x, 17);
    endfunction

    function automatic logic [31:0] p1(input logic [31:0] x);
        return x ^ rotl(x, 15) ^ rotl(x, 23);
    endfunction

    function automatic logic [255:0] sm3_cf(input logic [255:0] v, input logic [511:0] b);
        logic [31:0] w [68];
        logic [31:0] w1 [64];
        logic [31:0] a, bb, c, d, e, f, g, h, t, ss1, ss2, tt1, tt2, ff, gg;
        for (int j = 0; j < 16; j++) w[j] = b[511-32*j -: 32];
        for (int j = 16; j < 68; j++)
            w[j] = p1(w[j-16] ^ w[j-9] ^ rotl(w[j-3], 15)) ^ rotl(w[j-13], 7) ^ w[j-6];
        for (int j = 0; j < 64; j++) w1[j] = w[j] ^ w[j+4];
        {a, bb, c, d, e, f, g, h} = v;
        for (int j = 0; j < 64; j++) begin
            t   = (j < 16) ? 32'h79cc4519 : 32'h7a879d8a;
            ss1 = rotl(rotl(a, 12) + e + rotl(t, j), 7);
            ss2 = ss1 ^ rotl(a, 12);
            ff  = (j < 16) ? (a ^ bb ^ c) : ((a & bb) | (a & c) | (bb & c));
            gg  = (j < 16) ? (e ^ f ^ g) : ((e & f) | (~e & g));
            tt1 = ff + d + ss2 + w1[j];
            tt2 = gg + h + ss1 + w[j];
            d  = c;
            c  = rotl(bb, 9);
            bb = a;
            a  = tt1;
            h  = g;
            g  = rotl(f, 19);
            f  = e;
            e  = p0(tt2);
        end
        return {a, bb, c, d, e, f, g, h} ^ v;
    endfunction

    // Reference: pad the byte string as a whole, slice into blocks, chain V from IV.
    task automatic model_push(input bq_t m, output int nblk);
        bq_t          p;
        logic [63:0]  bits;
        logic [511:0] blk;
        logic [255:0] v;
        p = m;
        p.push_back(8'h80);
        while ((p.size() % 64) != 56) p.push_back(8'h00);
        bits = 64'(m.size()) * 64'd8;
        for (int i = 7; i >= 0; i--) p.push_back(bits[8*i +: 8]);
        nblk = p.size() / 64;
        v = IV;
        for (int bi = 0; bi < nblk; bi++) begin
            blk = '0;
            for (int k = 0; k < 64; k++) blk[511-8*k -: 8] = p[64*bi+k];
            exp_blk.push_back(blk);
            exp_v1.push_back(v);
            v = sm3_cf(v, blk);
        end
        exp_dig.push_back(v);
    endtask

    // Behavioural compression core: random latency, one-cycle cf_end, aborts on reset.
    initial begin
        logic [255:0] v1c;
        logic [511:0] bc;
        int           lat;
        bit           aborted;
        cf_end = 1'b0;
        cf_v2  = '0;
        forever begin
            @(negedge clk);
            if (!rst && cf_start) begin
                v1c = cf_v1;
                bc  = cf_block;
                if (lat_force > 0) lat = lat_force;
                else if ($urandom_range(0, 9) == 0) lat = 66;
                else lat = $urandom_range(1, 8);
                aborted = 1'b0;
                for (int k = 0; k < lat; k++) begin
                    @(negedge clk);
                    if (rst) begin
                        aborted = 1'b1;
                        break;
                    end
                end
                if (!aborted) begin
                    @(posedge clk); #1;
                    cf_end = 1'b1;
                    cf_v2  = sm3_cf(v1c, bc);
                    @(posedge clk); #1;
                    cf_end = 1'b0;
                    cf_v2  = {8{$urandom}};
                end
            end
        end
    end

    // Compare process: every cycle outside reset.
    initial begin
        bit       prev_start, prev_end, prev_dv;
        logic [255:0] e;
        prev_start = 1'b0;
        prev_end   = 1'b0;
        prev_dv    = 1'b0;
        held_dig   = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_start = 1'b0;
                prev_end   = 1'b0;
                prev_dv    = 1'b0;
                held_dig   = '0;
            end else begin
                if (cf_end) since_end = 0;
                else since_end++;
                if (prev_end) check("start_low_after_end", 512'(cf_start), 512'(0));
                if (cf_start) check("ready_low_in_run", 512'(in_ready), 512'(0));
                if (cf_start && !prev_start) begin
                    n_starts++;
                    if (exp_blk.size() == 0) begin
                        fail("unexpected_cf_start");
                    end else begin
                        held_blk = exp_blk.pop_front();
                        held_v1  = exp_v1.pop_front();
                        check("cf_block", cf_block, held_blk);
                        check("cf_v1", 512'(cf_v1), 512'(held_v1));
                        if (n_starts == 1) first_blk = cf_block;
                        last_blk = cf_block;
                    end
                end else if (cf_start) begin
                    check("cf_block_stable", cf_block, held_blk);
                    check("cf_v1_stable", 512'(cf_v1), 512'(held_v1));
                end
                if (!cf_start && prev_start && !prev_end) fail("cf_start_dropped_early");
                if (digest_valid) begin
                    if (prev_dv) fail("digest_valid_width");
                    if (exp_dig.size() == 0) begin
                        fail("stale_digest_valid");
                    end else begin
                        e = exp_dig.pop_front();
                        check("digest", 512'(digest), 512'(e));
                        check("digest_latency", 512'(since_end), 512'(2));
                        held_dig     = e;
                        last_dut_dig = digest;
                        dig_count++;
                    end
                end else begin
                    check("digest_held", 512'(digest), 512'(held_dig));
                end
                prev_start = cf_start;
                prev_end   = cf_end;
                prev_dv    = digest_valid;
            end
        end
    end

    task automatic drive(input bq_t m, input bit extra_empty);
        int n, nw, nb;
        bit got;
        logic [31:0] d;
        n  = m.size();
        nw = (n == 0) ? 1 : (n + 3) / 4;
        if (extra_empty) nw++;
        for (int i = 0; i < nw; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                in_valid = 1'b0;
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end
            d  = $urandom;
            nb = n - 4 * i;
            if (nb > 4) nb = 4;
            if (nb < 0) nb = 0;
            for (int k = 0; k < nb; k++) d[31-8*k -: 8] = m[4*i+k];
            in_data  = d;
            in_bytes = 3'(nb);
            in_last  = (i == nw - 1);
            in_valid = 1'b1;
            got = 1'b0;
            for (int t = 0; t < 600; t++) begin
                @(negedge clk);
                if (in_ready) begin
                    got = 1'b1;
                    break;
                end
            end
            if (!got) begin
                fail("word_accept_timeout");
                in_valid = 1'b0;
                return;
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_digest(input int target);
        for (int t = 0; t < 4000; t++) begin
            @(negedge clk);
            if (dig_count >= target) return;
        end
        fail("digest_timeout");
    endtask

    task automatic run_msg(input bq_t m, input bit extra_empty);
        int nb_exp, target;
        @(posedge clk); #1;
        n_starts = 0;
        model_push(m, nb_exp);
        target = dig_count + 1;
        drive(m, extra_empty);
        wait_digest(target);
        check("block_count", 512'(n_starts), 512'(nb_exp));
    endtask

    initial begin
        bq_t m;
        int  nb_dummy, len, r;
        bit  ex, seen;
        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;
        in_bytes = '0;
        in_last  = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_in_ready", 512'(in_ready), 512'(0));
        check("rst_cf_start", 512'(cf_start), 512'(0));
        check("rst_cf_v1", 512'(cf_v1), 512'(IV));
        check("rst_cf_block", cf_block, 512'(0));
        check("rst_digest", 512'(digest), 512'(0));
        check("rst_digest_valid", 512'(digest_valid), 512'(0));
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("idle_in_ready", 512'(in_ready), 512'(1));

        m = {8'h61, 8'h62, 8'h63};
        run_msg(m, 1'b0);
        check("abc_digest", 512'(last_dut_dig),
              512'(256'h66c7f0f462eeedd9d1f2d46bdc10e4e24167c4875cf2f7a2297da02b8f4ba8e0));
        check("abc_word0", 512'(first_blk[511:480]), 512'(32'h61626380));
        check("abc_word15", 512'(first_blk[31:0]), 512'(32'h00000018));

        m = {};
        for (int i = 0; i < 16; i++) begin
            m.push_back(8'h61); m.push_back(8'h62); m.push_back(8'h63); m.push_back(8'h64);
        end
        run_msg(m, 1'b0);
        check("abcd16_digest", 512'(last_dut_dig),
              512'(256'hdebe9ff92275b8a138604889c18e5a4d6fdb70e5387e5765293dcba39c0c5732));
        check("abcd16_blocks", 512'(n_starts), 512'(2));
        check("abcd16_b2_word0", 512'(last_blk[511:480]), 512'(32'h80000000));
        check("abcd16_b2_word15", 512'(last_blk[31:0]), 512'(32'h00000200));

        m = {};
        run_msg(m, 1'b0);
        check("empty_digest", 512'(last_dut_dig),
              512'(256'h1ab21d8355cfa17f8e61194831e81a8f22bec8c728fefb747ed035eb5082aa2b));
        check("empty_block", first_blk, {32'h80000000, 480'd0});

        m = {};
        for (int i = 0; i < 56; i++) m.push_back(8'($urandom));
        run_msg(m, 1'b0);
        check("len56_blocks", 512'(n_starts), 512'(2));

        // Reset while the core is busy, then a clean "abc".
        @(posedge clk); #1;
        lat_force = 66;
        n_starts  = 0;
        m = {8'h61, 8'h62, 8'h63};
        model_push(m, nb_dummy);
        drive(m, 1'b0);
        seen = 1'b0;
        for (int t = 0; t < 100; t++) begin
            @(negedge clk);
            if (cf_start) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) fail("midrun_start_timeout");
        repeat (5) @(negedge clk);
        #2;
        rst = 1'b1;
        exp_blk.delete();
        exp_v1.delete();
        exp_dig.delete();
        #1;
        check("midrun_rst_cf_start", 512'(cf_start), 512'(0));
        check("midrun_rst_cf_v1", 512'(cf_v1), 512'(IV));
        check("midrun_rst_digest_valid", 512'(digest_valid), 512'(0));
        repeat (2) @(negedge clk);
        rst = 1'b0;
        lat_force = 0;
        m = {8'h61, 8'h62, 8'h63};
        run_msg(m, 1'b0);
        check("post_rst_abc_digest", 512'(last_dut_dig),
              512'(256'h66c7f0f462eeedd9d1f2d46bdc10e4e24167c4875cf2f7a2297da02b8f4ba8e0));

        for (int it = 0; it < 16; it++) begin
            r = $urandom_range(0, 2);
            if (r == 0) len = $urandom_range(52, 64);
            else if (r == 1) len = $urandom_range(0, 12);
            else len = $urandom_range(0, 200);
            m = {};
            for (int i = 0; i < len; i++) m.push_back(8'($urandom));
            ex = (len > 0 && (len % 4) == 0) ? 1'($urandom_range(0, 1)) : 1'b0;
            run_msg(m, ex);
        end

        repeat (20) @(negedge clk);
        check("no_pending_digests", 512'(exp_dig.size()), 512'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
